// File: rtl/trachtenberg_pkg.sv
// trachtenberg_pkg
// Shared definitions for the Trachtenberg column multiplier.
//   TB_WIDTH     : default operand width in bits
//   TB_RWIDTH    : default result width (always twice the operand width)
//   tb_state_t   : handshake FSM states (IDLE accepts work, CALC finishes it)
//   carry_width  : bits needed for the inter-column carry/sum of a column
package trachtenberg_pkg;

  localparam int TB_WIDTH  = 5;
  localparam int TB_RWIDTH = 2 * TB_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } tb_state_t;

  // A column holds at most `width` partial products plus an incoming carry
  // that never reaches `width`, so every column sum stays below 2*width.
  // One extra bit keeps the sum register comfortably wide.
  function automatic int carry_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/trachtenberg_column.sv
// trachtenberg_column
// One result column of the Trachtenberg multiplier: adds every AND partial
// product whose bit indices sum to this column, plus the carry from the
// column below. Pure combinational.
// Ports:
//   terms     in  WIDTH : AND partial products of this column (unused slots tied 0)
//   carry_in  in  CW    : carry from column k-1 (zero for column 0)
//   res_bit   out 1     : result bit k (sum mod 2)
//   carry_out out CW    : carry into column k+1 (sum >> 1)
module trachtenberg_column
  import trachtenberg_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int CW    = carry_width(TB_WIDTH)
) (
  input  logic [WIDTH-1:0] terms,
  input  logic [CW-1:0]    carry_in,
  output logic             res_bit,
  output logic [CW-1:0]    carry_out
);

  logic [CW-1:0] col_sum;

  // Population count of the partial products, seeded with the carry.
  always_comb begin
    col_sum = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      col_sum = col_sum + CW'(terms[i]);
    end
  end

  assign res_bit   = col_sum[0];
  assign carry_out = col_sum >> 1;

endmodule

// File: rtl/trachtenberg_multiplier.sv
// trachtenberg_multiplier
// Two-stage unsigned multiplier with a start/valid handshake. Operands are
// captured on the start edge; on the following edge the column-wise product
// is registered into ores together with a one-cycle ovalid pulse.
// Ports:
//   iclk   in  1        : clock, rising edge
//   irst   in  1        : synchronous active-high reset
//   istart in  1        : start request, honoured only while oready=1
//   ia     in  WIDTH    : multiplicand (unsigned)
//   ib     in  WIDTH    : multiplier (unsigned)
//   oready out 1        : idle, able to accept istart
//   ovalid out 1        : one-cycle pulse when ores holds a new product
//   ores   out 2*WIDTH  : registered product, held until the next result
module trachtenberg_multiplier
  import trachtenberg_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 istart,
  input  logic [WIDTH-1:0]     ia,
  input  logic [WIDTH-1:0]     ib,
  output logic                 oready,
  output logic                 ovalid,
  output logic [2*WIDTH-1:0]   ores
);

  localparam int RWIDTH = 2 * WIDTH;
  localparam int CW     = carry_width(WIDTH);

  tb_state_t         state;
  tb_state_t         state_next;
  logic [WIDTH-1:0]  ra;
  logic [WIDTH-1:0]  rb;
  logic [RWIDTH-1:0] col_prod;
  logic [CW-1:0]     unused_final_carry;

  // State register.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: CALC always lasts exactly one cycle, so a start arriving on
  // the completing edge is dropped rather than queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (istart) state_next = CALC;
      CALC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    oready = (state == IDLE);
  end

  // Operand capture; later ia/ib changes cannot disturb the in-flight product.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ra <= '0;
      rb <= '0;
    end else if (state == IDLE && istart) begin
      ra <= ia;
      rb <= ib;
    end
  end

  // Result register; reset during CALC aborts the operation with no pulse.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ores   <= '0;
      ovalid <= 1'b0;
    end else if (state == CALC) begin
      ores   <= col_prod;
      ovalid <= 1'b1;
    end else begin
      ovalid <= 1'b0;
    end
  end

  // Column array: column k gathers ra[i]&rb[k-i] for every valid i and
  // ripples its carry upward. The carry out of the top column is always
  // zero because the full product fits in RWIDTH bits.
  for (genvar k = 0; k < RWIDTH; k++) begin : g_col
    logic [WIDTH-1:0] terms;
    logic [CW-1:0]    cin;
    logic [CW-1:0]    cout;

    for (genvar i = 0; i < WIDTH; i++) begin : g_term
      localparam int J = k - i;
      if (J >= 0 && J < WIDTH) begin : g_and
        assign terms[i] = ra[i] & rb[J];
      end else begin : g_zero
        assign terms[i] = 1'b0;
      end
    end

    if (k == 0) begin : g_first
      assign cin = '0;
    end else begin : g_chain
      assign cin = g_col[k-1].cout;
    end

    trachtenberg_column #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_column (
      .terms     (terms),
      .carry_in  (cin),
      .res_bit   (col_prod[k]),
      .carry_out (cout)
    );
  end

  assign unused_final_carry = g_col[RWIDTH-1].cout;

endmodule

// File: tb/tb_trachtenberg_multiplier.sv
// tb_trachtenberg_multiplier
// Scoreboarded bench for trachtenberg_multiplier: a transaction-level
// reference pushes a*b when a start is accepted, and a monitor pops and
// compares whenever the DUT pulses ovalid. Handshake outputs are also
// compared every cycle against the reference's view of the protocol.
module tb_trachtenberg_multiplier;
  import trachtenberg_pkg::*;

  localparam int W = TB_WIDTH;

  logic           iclk   = 1'b0;
  logic           irst   = 1'b1;
  logic           istart = 1'b0;
  logic [W-1:0]   ia     = '0;
  logic [W-1:0]   ib     = '0;
  logic           oready;
  logic           ovalid;
  logic [2*W-1:0] ores;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_q[$];
  bit          ref_busy  = 1'b0;
  bit          ref_valid = 1'b0;
  int unsigned ref_ores  = 0;
  int unsigned ref_pend  = 0;

  trachtenberg_multiplier #(.WIDTH(W)) dut (
    .iclk   (iclk),
    .irst   (irst),
    .istart (istart),
    .ia     (ia),
    .ib     (ib),
    .oready (oready),
    .ovalid (ovalid),
    .ores   (ores)
  );

  always #5 iclk = ~iclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, changed on the falling edge.
  task automatic applyStimulus(input int a, input int b, input bit start, input bit rst);
    @(negedge iclk);
    ia     = W'(a);
    ib     = W'(b);
    istart = start;
    irst   = rst;
  endtask

  // Protocol-level reference: an accepted start yields a*b one edge later;
  // a reset while busy discards the pending product.
  always @(posedge iclk) begin
    ref_valid = 1'b0;
    if (irst) begin
      if (ref_busy) void'(exp_q.pop_back());
      ref_busy = 1'b0;
      ref_ores = 0;
    end else if (ref_busy) begin
      ref_busy  = 1'b0;
      ref_ores  = ref_pend;
      ref_valid = 1'b1;
    end else if (istart) begin
      ref_pend = int'(ia) * int'(ib);
      exp_q.push_back(ref_pend);
      ref_busy = 1'b1;
    end
  end

  // Monitor: compare handshake every cycle, pop the scoreboard on ovalid.
  always @(negedge iclk) begin
    checkOutput("oready", 32'(oready), 32'(!ref_busy));
    checkOutput("ovalid", 32'(ovalid), 32'(ref_valid));
    checkOutput("ores_hold", 32'(ores), ref_ores);
    if (ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty actual=%0d expected=none at %0t", ores, $time);
      end else begin
        checkOutput("scoreboard", 32'(ores), exp_q.pop_front());
      end
    end
  end

  initial begin
    int corner_a[4] = '{0, 31, 31, 1};
    int corner_b[4] = '{0, 1, 31, 31};
    bit got;

    // Reset, then idle.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    repeat (5) applyStimulus(0, 0, 0, 0);

    // Basic product and result hold.
    applyStimulus(21, 10, 1, 0);
    repeat (5) applyStimulus(21, 10, 0, 0);

    // Corners.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(corner_a[i], corner_b[i], 1, 0);
      repeat (3) applyStimulus(0, 0, 0, 0);
    end

    // Start during CALC with new operands is ignored.
    applyStimulus(17, 19, 1, 0);
    applyStimulus(3, 3, 1, 0);
    repeat (4) applyStimulus(3, 3, 0, 0);

    // Reset on the CALC edge aborts the operation.
    applyStimulus(25, 25, 1, 0);
    applyStimulus(25, 25, 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 0);

    // Exhaustive sweep, waiting a bounded time for each result.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        applyStimulus(a, b, 1, 0);
        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
          applyStimulus(a, b, 0, 0);
          if (ovalid === 1'b1) got = 1'b1;
        end
        checkOutput("valid_timeout", 32'(got), 32'd1);
      end
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    // Start held high: restarts on every idle cycle.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, 0);
    end

    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
